// File: rtl/npu_deb_pkg.sv
// Shared definitions for the NPU byte-wide debug link (PISO transmitter and SIPO receiver).
// Holds the frame field map, the receiver state encoding and small arithmetic helpers.
package npu_deb_pkg;

    localparam int FRAME_BYTES = 12;
    localparam int STAGE_BYTES = FRAME_BYTES - 1;

    localparam int IDX_SSFR_H = 0;
    localparam int IDX_SSFR_L = 1;
    localparam int IDX_CON_H  = 2;
    localparam int IDX_CON_L  = 3;
    localparam int IDX_MAC2_H = 4;
    localparam int IDX_MAC2_L = 5;
    localparam int IDX_MAC1_H = 6;
    localparam int IDX_MAC1_L = 7;
    localparam int IDX_DD     = 8;
    localparam int IDX_DC     = 9;
    localparam int IDX_DB     = 10;
    localparam int IDX_DA     = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DONE = 2'd2
    } deb_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        sat_inc8 = (value == 8'hFF) ? 8'hFF : value + 8'd1;
    endfunction

endpackage

// File: rtl/sipo_deb_timer.sv
// Idle-cycle counter for the debug SIPO: counts gap cycles inside a frame and flags
// the increment that reaches the timeout limit. Saturates at the limit, never wraps.
module sipo_deb_timer #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC);
    localparam logic [CW-1:0] ONE   = CW'(1);

    logic [CW-1:0] count_r;

    // Gap counter with synchronous clear and saturation at the limit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (inc && (count_r != LIMIT)) begin
            count_r <= count_r + ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = inc && (count_r == (LIMIT - ONE));

endmodule

// File: rtl/sipo_deb.sv
// Receive side of the NPU debug link: reassembles the 12-byte snapshot stream into
// parallel field registers, published atomically on the last byte; aborted frames are counted.
module sipo_deb
    import npu_deb_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        CLKEXT,
    input  logic        RST_GLO_N,
    input  logic        EN_SIPO_DEB,
    input  logic        CLR_SIPO_DEB,
    input  logic        SHIFT_DEB,
    input  logic [7:0]  D_IN,
    output logic [15:0] SSFR,
    output logic [15:0] CON_SIG,
    output logic [15:0] MAC2,
    output logic [15:0] MAC1,
    output logic [7:0]  DD,
    output logic [7:0]  DC,
    output logic [7:0]  DB,
    output logic [7:0]  DA,
    output logic        FRAME_VLD,
    output logic        FRAME_ERR,
    output logic [3:0]  BYTE_CNT,
    output logic [7:0]  ERR_CNT
);

    localparam logic [3:0] LAST_IDX = 4'(FRAME_BYTES - 1);

    deb_state_e state_r;
    deb_state_e next_state_s;
    logic [7:0] stage_r [0:STAGE_BYTES-1];
    logic       accept_s;
    logic       publish_s;
    logic       abort_s;
    logic       timer_inc_s;
    logic       timer_clr_s;
    logic       timer_expired_s;

    sipo_deb_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk     (CLKEXT),
        .rst_n   (RST_GLO_N),
        .clr     (timer_clr_s),
        .inc     (timer_inc_s),
        .expired (timer_expired_s)
    );

    // Next-state and per-edge action decode; clear is applied with priority in the register block.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        publish_s    = 1'b0;
        abort_s      = 1'b0;
        timer_inc_s  = 1'b0;
        timer_clr_s  = 1'b1;
        if (CLR_SIPO_DEB) begin
            next_state_s = ST_IDLE;
        end else if (!EN_SIPO_DEB) begin
            next_state_s = ST_IDLE;
            abort_s      = (state_r == ST_RECV);
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (SHIFT_DEB) begin
                        accept_s     = 1'b1;
                        next_state_s = ST_RECV;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end
                ST_RECV: begin
                    if (SHIFT_DEB) begin
                        accept_s = 1'b1;
                        if (BYTE_CNT == LAST_IDX) begin
                            publish_s    = 1'b1;
                            next_state_s = ST_DONE;
                        end else begin
                            next_state_s = ST_RECV;
                        end
                    end else begin
                        timer_inc_s = 1'b1;
                        timer_clr_s = 1'b0;
                        if (timer_expired_s) begin
                            abort_s      = 1'b1;
                            next_state_s = ST_IDLE;
                        end else begin
                            next_state_s = ST_RECV;
                        end
                    end
                end
                // The transmitter keeps its last byte on the bus while the strobe stays high.
                ST_DONE: begin
                    if (SHIFT_DEB) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end
                default: begin
                    next_state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, staging buffer, field outputs, status pulses and counters.
    always_ff @(posedge CLKEXT) begin
        if (!RST_GLO_N || CLR_SIPO_DEB) begin
            state_r   <= ST_IDLE;
            SSFR      <= 16'h0000;
            CON_SIG   <= 16'h0000;
            MAC2      <= 16'h0000;
            MAC1      <= 16'h0000;
            DD        <= 8'h00;
            DC        <= 8'h00;
            DB        <= 8'h00;
            DA        <= 8'h00;
            FRAME_VLD <= 1'b0;
            FRAME_ERR <= 1'b0;
            BYTE_CNT  <= 4'd0;
            ERR_CNT   <= 8'h00;
            for (int i = 0; i < STAGE_BYTES; i++) begin
                stage_r[i] <= 8'h00;
            end
        end else begin
            state_r   <= next_state_s;
            FRAME_VLD <= publish_s;
            FRAME_ERR <= abort_s;
            if (abort_s) begin
                ERR_CNT  <= sat_inc8(ERR_CNT);
                BYTE_CNT <= 4'd0;
                for (int i = 0; i < STAGE_BYTES; i++) begin
                    stage_r[i] <= 8'h00;
                end
            end else if (publish_s) begin
                // Last byte bypasses staging so every field comes from the same frame.
                SSFR     <= {stage_r[IDX_SSFR_H], stage_r[IDX_SSFR_L]};
                CON_SIG  <= {stage_r[IDX_CON_H],  stage_r[IDX_CON_L]};
                MAC2     <= {stage_r[IDX_MAC2_H], stage_r[IDX_MAC2_L]};
                MAC1     <= {stage_r[IDX_MAC1_H], stage_r[IDX_MAC1_L]};
                DD       <= stage_r[IDX_DD];
                DC       <= stage_r[IDX_DC];
                DB       <= stage_r[IDX_DB];
                DA       <= D_IN;
                BYTE_CNT <= 4'd0;
            end else if (accept_s) begin
                stage_r[BYTE_CNT] <= D_IN;
                BYTE_CNT          <= BYTE_CNT + 4'd1;
            end else begin
                BYTE_CNT <= BYTE_CNT;
            end
        end
    end

endmodule
